// File: rtl/lfsr_pkg.sv
// Shared LFSR helpers: next-state function and
// a maximal-length tap table for widths 2..32.
package lfsr_pkg;

  localparam int unsigned MAX_W = 32;

  // Bit i set means the x^(i+1) term is present.
  localparam logic [31:0] MAX_TAPS [0:32] = '{
    32'h0000_0000, 32'h0000_0000,
    32'h0000_0003, 32'h0000_0006,
    32'h0000_000C, 32'h0000_0014,
    32'h0000_0030, 32'h0000_0060,
    32'h0000_00B8, 32'h0000_0110,
    32'h0000_0240, 32'h0000_0500,
    32'h0000_0829, 32'h0000_100D,
    32'h0000_2015, 32'h0000_6000,
    32'h0000_D008, 32'h0001_2000,
    32'h0002_0400, 32'h0004_0023,
    32'h0009_0000, 32'h0014_0000,
    32'h0030_0000, 32'h0042_0000,
    32'h00E1_0000, 32'h0120_0000,
    32'h0200_0023, 32'h0400_0013,
    32'h0900_0000, 32'h1400_0000,
    32'h2000_0029, 32'h4800_0000,
    32'h8020_0003
  };

  function automatic logic [31:0] lfsr_next(
    input logic [31:0] state,
    input logic [31:0] taps,
    input int unsigned width,
    input logic        galois
  );
    logic [31:0] mask;
    logic [31:0] sh;
    logic [31:0] m;
    logic        fb;
    mask = (width >= MAX_W) ? '1
         : ((32'd1 << width) - 32'd1);
    sh = (state << 1) & mask;
    m  = ((taps << 1) | 32'd1) & mask;
    fb = ^(state & taps & mask);
    if (galois)
      lfsr_next = state[width-1] ? (sh ^ m) : sh;
    else
      lfsr_next = sh | {31'd0, fb};
  endfunction

endpackage

// File: rtl/lfsr_gen_period_mon.sv
// Tracks the start state, counts steps and
// reports the length of each completed cycle.
module lfsr_period_mon
  import lfsr_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] q_next,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] period,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ALL1 = '1;

  logic [WIDTH-1:0] start_r;
  logic [WIDTH-1:0] cnt_r;
  logic [WIDTH-1:0] cnt_inc;
  logic             hit;

  always_comb begin
    hit     = (q_next == start_r);
    cnt_inc = (cnt_r == ALL1) ? ALL1
            : cnt_r + WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_r <= RESET_VAL;
      cnt_r   <= '0;
      period  <= '0;
      wrap    <= 1'b0;
    end else if (load) begin
      start_r <= load_val;
      cnt_r   <= '0;
      wrap    <= 1'b0;
    end else if (step) begin
      wrap <= hit;
      if (hit) begin
        // Saturated count stays all-ones.
        period <= cnt_inc;
        cnt_r  <= '0;
      end else begin
        cnt_r  <= cnt_inc;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci/Galois LFSR with seed
// load, all-zero recovery and period monitor.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH  = 4,
  parameter logic [WIDTH-1:0] TAPS   = 4'b1100,
  parameter logic [WIDTH-1:0] SEED   = WIDTH'(1),
  parameter int               GALOIS = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] q,
  output logic             out_bit,
  output logic             lockup,
  output logic             wrap,
  output logic [WIDTH-1:0] period
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] INIT =
    (SEED == '0) ? ONE : SEED;

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] seed_fix;
  logic             q_zero;
  logic             seed_zero;
  logic             step;
  logic             lockup_r;

  always_comb begin
    q_zero    = (q_r == '0);
    seed_zero = (seed_in == '0);
    seed_fix  = seed_zero ? ONE : seed_in;
    step      = en & ~load;
    // All-zero is a dead state; escape to 1.
    q_step = q_zero ? ONE
           : WIDTH'(lfsr_next(32'(q_r),
                              32'(TAPS),
                              WIDTH,
                              GALOIS != 0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_r      <= INIT;
      lockup_r <= 1'b0;
    end else if (load) begin
      q_r      <= seed_fix;
      lockup_r <= seed_zero;
    end else if (en) begin
      q_r      <= q_step;
      lockup_r <= q_zero;
    end else begin
      lockup_r <= 1'b0;
    end
  end

  lfsr_period_mon #(
    .WIDTH     (WIDTH),
    .RESET_VAL (INIT)
  ) u_mon (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .q_next   (q_step),
    .load_val (seed_fix),
    .period   (period),
    .wrap     (wrap)
  );

  assign q       = q_r;
  assign out_bit = q_r[WIDTH-1];
  assign lockup  = lockup_r;

endmodule
